req_dispatch3: RTL and testbench



---
 rtl/req_dispatch_pkg.sv | 6 +
 rtl/req_dest_decode.sv | 10 +
 rtl/req_dispatch3.sv | 49 ++++
 tb/tb_req_dispatch3.sv | 124 ++++++++++++
 4 files changed

// File: rtl/req_dispatch_pkg.sv
// req_dispatch_pkg: shared constants and FSM encoding for req_dispatch3
package req_dispatch_pkg;
  localparam int NUM_TGT = 3;
  localparam logic [1:0] DEST_BCAST = 2'd3;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/req_dest_decode.sv
// req_dest_decode: 2-bit destination to one-hot target mask, all-ones on broadcast
module req_dest_decode
  import req_dispatch_pkg::*;
(
  input  logic [1:0]         dest,
  output logic [NUM_TGT-1:0] mask
);
  // broadcast selects every target, otherwise exactly one
  always_comb mask = dest == DEST_BCAST ? '1 : NUM_TGT'(1) << dest;
endmodule

// File: rtl/req_dispatch3.sv
// req_dispatch3: single-entry dispatcher to three targets with broadcast; REQ_DISPATCH_PIPE_EN enables back-to-back accept
module req_dispatch3
  import req_dispatch_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [1:0]         in_dest,
  output logic [NUM_TGT-1:0] out_valid,
  input  logic [NUM_TGT-1:0] out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [7:0]         done_cnt
);
  state_t state, state_nx;
  logic [NUM_TGT-1:0] pending, dmask;
  logic last, acc;
  req_dest_decode u_dec (.dest(in_dest), .mask(dmask));
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // next state and handshake outputs; last marks the edge that drains the mask
  always_comb begin
    last = state == SEND && (pending & ~out_ready) == '0;
`ifdef REQ_DISPATCH_PIPE_EN
    in_ready = state == IDLE || last;
`else
    in_ready = state == IDLE;
`endif
    acc = in_valid && in_ready;
    state_nx = acc ? SEND : last ? IDLE : state;
    out_valid = state == SEND ? pending : '0;
  end
  // payload, pending mask and completion counter
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_data <= '0;
      pending <= '0;
      done_cnt <= '0;
    end else begin
      out_data <= acc ? in_data : out_data;
      pending <= acc ? dmask : state == SEND ? pending & ~out_ready : pending;
      done_cnt <= done_cnt + 8'(last);
    end
endmodule

// File: tb/tb_req_dispatch3.sv
// tb_req_dispatch3: directed self-checking bench for req_dispatch3
module tb_req_dispatch3;
  logic clk = 0, rst = 1, in_valid = 0, in_ready;
  logic [7:0] in_data = '0, out_data, done_cnt;
  logic [1:0] in_dest = '0;
  logic [2:0] out_valid, out_ready = '0;
  int vectors = 0, miscompares = 0;
`ifdef REQ_DISPATCH_PIPE_EN
  localparam bit PIPE = 1;
  localparam int TICKS = 256, MID = 19;
`else
  localparam bit PIPE = 0;
  localparam int TICKS = 512, MID = 10;
`endif

  req_dispatch3 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #3;
    check("rst_in_ready", 8'(in_ready), 8'h1);
    check("rst_out_valid", 8'(out_valid), 8'h0);
    check("rst_out_data", out_data, 8'h0);
    check("rst_done_cnt", done_cnt, 8'h0);
    #9 rst = 0;
    // single request to target 1, all ready
    in_valid = 1; in_dest = 1; in_data = 8'hA5; out_ready = 3'b111;
    tick;
    in_valid = 0; in_data = 8'h00;
    check("single_valid", 8'(out_valid), 8'h2);
    check("single_data", out_data, 8'hA5);
    check("single_in_ready", 8'(in_ready), 8'(PIPE));
    check("single_done_pre", done_cnt, 8'h0);
    tick;
    check("single_valid_end", 8'(out_valid), 8'h0);
    check("single_done", done_cnt, 8'h1);
    check("single_in_ready_end", 8'(in_ready), 8'h1);
    // broadcast with staggered readies
    in_valid = 1; in_dest = 3; in_data = 8'h3C; out_ready = 3'b000;
    tick;
    in_valid = 0;
    check("bc_111", 8'(out_valid), 8'h7);
    out_ready = 3'b001;
    tick;
    check("bc_110", 8'(out_valid), 8'h6);
    check("bc_done_1", done_cnt, 8'h1);
    out_ready = 3'b100;
    tick;
    check("bc_010", 8'(out_valid), 8'h2);
    check("bc_done_2", done_cnt, 8'h1);
    out_ready = 3'b010;
    tick;
    check("bc_000", 8'(out_valid), 8'h0);
    check("bc_done_3", done_cnt, 8'h2);
    check("bc_data", out_data, 8'h3C);
    // backpressure on target 2, competing request must be refused
    in_valid = 1; in_dest = 2; in_data = 8'h5A; out_ready = 3'b000;
    tick;
    in_dest = 0; in_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 8'(out_valid), 8'h4);
      check("bp_data", out_data, 8'h5A);
      check("bp_in_ready", 8'(in_ready), 8'h0);
      tick;
    end
    in_valid = 0; out_ready = 3'b100;
    tick;
    check("bp_valid_end", 8'(out_valid), 8'h0);
    check("bp_done", done_cnt, 8'h3);
    check("bp_data_end", out_data, 8'h5A);
    // asynchronous reset with broadcast partly delivered
    in_valid = 1; in_dest = 3; in_data = 8'h77; out_ready = 3'b000;
    tick;
    in_valid = 0; out_ready = 3'b001;
    tick;
    check("mid_110", 8'(out_valid), 8'h6);
    out_ready = 3'b000;
    #1 rst = 1;
    #1;
    check("mid_rst_valid", 8'(out_valid), 8'h0);
    check("mid_rst_done", done_cnt, 8'h0);
    check("mid_rst_data", out_data, 8'h0);
    #1 rst = 0;
    check("mid_in_ready", 8'(in_ready), 8'h1);
    check("mid_valid_after", 8'(out_valid), 8'h0);
    // streaming with all ready: throughput and done_cnt wrap
    in_valid = 1; out_ready = 3'b111;
    for (int i = 1; i <= TICKS; i++) begin
      in_dest = 2'(i % 3);
      in_data = 8'(i);
      tick;
      if (i <= 4) begin
        check("stream_in_ready", 8'(in_ready), PIPE ? 8'h1 : 8'(i % 2 == 0));
        check("stream_valid", 8'(out_valid), (PIPE || i % 2 == 1) ? 8'(3'b001 << (i % 3)) : 8'h0);
      end
      if (i == 20) check("stream_rate", done_cnt, 8'(MID));
    end
    in_valid = 0;
    tick;
    check("wrap_done", done_cnt, 8'h0);
    check("wrap_valid", 8'(out_valid), 8'h0);
    check("wrap_in_ready", 8'(in_ready), 8'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
